// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM ring-buffer controller: access-history
// state encoding and default geometry constants.
package sram_ctrl_pkg;

    // Records which kind of SRAM access happened on the previous cycle
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2
    } state_t;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_DEPTH      = 256;

endpackage

// File: rtl/sram_buffer_ctrl_rr_grant2.sv
// Two-requester grant selector (write / read) for the single SRAM port.
// Priority flips away from whichever side was served last, so two
// continuously active requesters alternate cycle by cycle.
module rr_grant2
    import sram_ctrl_pkg::*;
(
    input  logic   req_wr,
    input  logic   req_rd,
    input  state_t last,
    output logic   gnt_wr,
    output logic   gnt_rd
);

    logic rd_first;

    // Read wins a conflict only right after a write; otherwise write wins
    always_comb begin
        rd_first = (last == S_WR);
        gnt_wr   = req_wr && !(rd_first && req_rd);
        gnt_rd   = req_rd && !(!rd_first && req_wr);
    end

endmodule

// File: rtl/sram_buffer_ctrl.sv
// Ring-buffer controller for the single-port SRAM sample store.
// Producer writes via valid/ready, consumer reads via req/ack with data
// one cycle after ack. One SRAM access per cycle.
// Optional feature macro: SRAM_BUFFER_CTRL_STATUS_EN adds sticky
// o_overflow / o_underflow status outputs.
//
// Handshake semantics: a write transfers on a cycle where i_wr_valid and
// o_wr_ready are both high; a read is granted on a cycle where o_rd_ack
// is high, and its sample appears on o_rd_data with o_rd_valid the
// following cycle. o_wr_ready never depends on anything but eligibility
// and arbitration, and both handshake outputs are held low during reset.
module sram_buffer_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr_valid,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic                  o_wr_ready,
    input  logic                  i_rd_req,
    output logic                  o_rd_ack,
    output logic                  o_rd_valid,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic [ADDR_WIDTH-1:0] o_sram_addr,
    output logic                  o_sram_write_EN,
    output logic [DATA_WIDTH-1:0] o_sram_data,
    input  logic [DATA_WIDTH-1:0] i_sram_data,
    output logic [ADDR_WIDTH:0]   o_count,
    output logic                  o_full,
    output logic                  o_empty,
`ifdef SRAM_BUFFER_CTRL_STATUS_EN
    output logic                  o_overflow,
    output logic                  o_underflow,
`endif
    output logic [1:0]            o_state
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(DEPTH - 1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_hold_q;
    logic                  rd_valid_q;
    logic                  wr_elig, rd_elig;
    logic                  gnt_wr, gnt_rd;

    assign o_full  = (count_q == DEPTH_CNT);
    assign o_empty = (count_q == '0);
    assign o_count = count_q;
    assign o_state = state_q;

    // Eligibility; gated by reset so nothing is granted while rst is low
    always_comb begin
        wr_elig = rst && i_wr_valid && !o_full;
        rd_elig = rst && i_rd_req && !o_empty;
    end

    rr_grant2 u_grant (
        .req_wr (wr_elig),
        .req_rd (rd_elig),
        .last   (state_q),
        .gnt_wr (gnt_wr),
        .gnt_rd (gnt_rd)
    );

    // Next-state and SRAM/handshake outputs; address and data hold when idle
    always_comb begin
        state_d         = S_IDLE;
        o_wr_ready      = 1'b0;
        o_rd_ack        = 1'b0;
        o_sram_write_EN = 1'b0;
        o_sram_addr     = addr_q;
        o_sram_data     = wdata_q;
        if (gnt_wr) begin
            state_d         = S_WR;
            o_wr_ready      = 1'b1;
            o_sram_write_EN = 1'b1;
            o_sram_addr     = wr_ptr_q;
            o_sram_data     = i_wr_data;
        end else if (gnt_rd) begin
            state_d     = S_RD;
            o_rd_ack    = 1'b1;
            o_sram_addr = rd_ptr_q;
        end
    end

    // Access-history state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Pointers wrap at DEPTH-1; occupancy moves by one per granted access
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (gnt_wr) begin
            wr_ptr_q <= (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 1'b1;
            count_q  <= count_q + (ADDR_WIDTH+1)'(1);
        end else if (gnt_rd) begin
            rd_ptr_q <= (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + 1'b1;
            count_q  <= count_q - (ADDR_WIDTH+1)'(1);
        end
    end

    // Remember the last driven address/data so the SRAM bus is stable when idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            addr_q  <= o_sram_addr;
            wdata_q <= o_sram_data;
        end
    end

    // Read-return: valid one cycle after ack, data taken from the SRAM register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid_q   <= 1'b0;
            rdata_hold_q <= '0;
        end else begin
            rd_valid_q <= gnt_rd;
            if (rd_valid_q) rdata_hold_q <= i_sram_data;
        end
    end

    assign o_rd_valid = rd_valid_q;
    assign o_rd_data  = rd_valid_q ? i_sram_data : rdata_hold_q;

`ifdef SRAM_BUFFER_CTRL_STATUS_EN
    // Sticky misuse flags, cleared only by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            if (i_wr_valid && o_full)  o_overflow  <= 1'b1;
            if (i_rd_req   && o_empty) o_underflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sram_buffer_ctrl.sv
// Self-checking bench for sram_buffer_ctrl with DEPTH=4 and a registered
// SRAM model. Expected behaviour comes from a queue-based buffer model.
module tb_sram_buffer_ctrl;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_wr_valid = 1'b0;
    logic [DW-1:0] i_wr_data = '0;
    logic          o_wr_ready;
    logic          i_rd_req = 1'b0;
    logic          o_rd_ack;
    logic          o_rd_valid;
    logic [DW-1:0] o_rd_data;
    logic [AW-1:0] o_sram_addr;
    logic          o_sram_write_EN;
    logic [DW-1:0] o_sram_data;
    logic [DW-1:0] i_sram_data;
    logic [AW:0]   o_count;
    logic          o_full;
    logic          o_empty;
    logic [1:0]    o_state;
`ifdef SRAM_BUFFER_CTRL_STATUS_EN
    logic          o_overflow;
    logic          o_underflow;
`endif

    always #5 clk = ~clk;

    sram_buffer_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(D)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_wr_valid      (i_wr_valid),
        .i_wr_data       (i_wr_data),
        .o_wr_ready      (o_wr_ready),
        .i_rd_req        (i_rd_req),
        .o_rd_ack        (o_rd_ack),
        .o_rd_valid      (o_rd_valid),
        .o_rd_data       (o_rd_data),
        .o_sram_addr     (o_sram_addr),
        .o_sram_write_EN (o_sram_write_EN),
        .o_sram_data     (o_sram_data),
        .i_sram_data     (i_sram_data),
        .o_count         (o_count),
        .o_full          (o_full),
        .o_empty         (o_empty),
`ifdef SRAM_BUFFER_CTRL_STATUS_EN
        .o_overflow      (o_overflow),
        .o_underflow     (o_underflow),
`endif
        .o_state         (o_state)
    );

    // Single-port SRAM with registered read data
    logic [DW-1:0] mem [0:255];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        i_sram_data = '0;
    end
    always @(posedge clk) begin
        if (o_sram_write_EN) mem[o_sram_addr] <= o_sram_data;
        i_sram_data <= mem[o_sram_addr];
    end

    // Reference model state
    logic [DW-1:0] exp_q[$];
    int            wr_idx, rd_idx, last_addr, last_op;
    bit            pend_valid;
    logic [DW-1:0] pend_data;
    bit            exp_ovf, exp_udf;
    int            n_vec = 0;
    int            n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        wr_idx = 0; rd_idx = 0; last_addr = 0; last_op = 0;
        pend_valid = 0; pend_data = '0;
        exp_ovf = 0; exp_udf = 0;
    endtask

    // One clock cycle: drive, check at negedge against the model, advance model
    task automatic step(input bit wv, input logic [DW-1:0] wd, input bit rq);
        bit we, re;
        int exp_addr;
        i_wr_valid = wv; i_wr_data = wd; i_rd_req = rq;
        @(negedge clk);
        we = wv && (exp_q.size() < D);
        re = rq && (exp_q.size() > 0);
        if (we && re) begin
            if (last_op == 1) we = 0;
            else              re = 0;
        end
        exp_addr = we ? wr_idx : (re ? rd_idx : last_addr);
        chk("wr_ready", o_wr_ready, we);
        chk("rd_ack",   o_rd_ack, re);
        chk("write_en", o_sram_write_EN, we);
        chk("addr",     o_sram_addr, exp_addr);
        chk("count",    o_count, exp_q.size());
        chk("full",     o_full, exp_q.size() == D);
        chk("empty",    o_empty, exp_q.size() == 0);
        chk("rd_valid", o_rd_valid, pend_valid);
        if (pend_valid) chk("rd_data", o_rd_data, pend_data);
        if (we) chk("sram_data", o_sram_data, wd);
        if (wv && exp_q.size() == D) exp_ovf = 1;
        if (rq && exp_q.size() == 0) exp_udf = 1;
        @(posedge clk);
        if (we) begin
            exp_q.push_back(wd);
            wr_idx  = (wr_idx + 1) % D;
            last_op = 1;
        end else if (re) begin
            pend_data = exp_q.pop_front();
            rd_idx  = (rd_idx + 1) % D;
            last_op = 2;
        end else begin
            last_op = 0;
        end
        pend_valid = re;
        last_addr  = exp_addr;
        #1;
`ifdef SRAM_BUFFER_CTRL_STATUS_EN
        chk("overflow",  o_overflow, exp_ovf);
        chk("underflow", o_underflow, exp_udf);
`endif
    endtask

    task automatic check_reset_values();
        chk("rst_count",    o_count, 0);
        chk("rst_empty",    o_empty, 1);
        chk("rst_full",     o_full, 0);
        chk("rst_rd_valid", o_rd_valid, 0);
        chk("rst_rd_data",  o_rd_data, 0);
        chk("rst_addr",     o_sram_addr, 0);
        chk("rst_sdata",    o_sram_data, 0);
        chk("rst_we",       o_sram_write_EN, 0);
        chk("rst_wr_ready", o_wr_ready, 0);
        chk("rst_rd_ack",   o_rd_ack, 0);
`ifdef SRAM_BUFFER_CTRL_STATUS_EN
        chk("rst_ovf", o_overflow, 0);
        chk("rst_udf", o_underflow, 0);
`endif
    endtask

    initial begin
        model_reset();
        // Reset state, with a write request held to prove ready stays low
        i_wr_valid = 1'b1; i_wr_data = 32'hdead_beef;
        #12;
        check_reset_values();
        i_wr_valid = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        // Fill to full, then a rejected fifth write
        step(1, 32'd10, 0);
        step(1, 32'd20, 0);
        step(1, 32'd30, 0);
        step(1, 32'd40, 0);
        chk("full_after_4", o_full, 1);
        step(1, 32'd50, 0);

        // Drain in order, then a request on an empty buffer
        for (int i = 0; i < 4; i++) step(0, '0, 1);
        step(0, '0, 0);
        chk("empty_after_drain", o_empty, 1);
        step(0, '0, 1);

        // Wrap-around: pointers run 0..3 then back to 0
        for (int i = 0; i < 6; i++) begin
            step(1, 32'h100 + i, 0);
            step(0, '0, 1);
        end
        step(0, '0, 0);

        // Contention from S_IDLE with two stored samples
        step(1, 32'haaa1, 0);
        step(1, 32'haaa2, 0);
        step(0, '0, 0);
        for (int i = 0; i < 6; i++) begin
            step(1, 32'hc000 + i, 1);
            chk("cont_count", (o_count == 2 || o_count == 3), 1);
        end
        step(0, '0, 0);

        // Randomized traffic
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
        for (int i = 0; i < 5; i++) step(0, '0, 1);
        step(0, '0, 0);

        // Async reset between read ack and data return
        step(1, 32'h77, 0);
        step(0, '0, 1);
        chk("pre_rst_valid", o_rd_valid, 1);
        i_wr_valid = 1'b1; i_wr_data = 32'h55;
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", o_rd_valid, 0);
        chk("mid_rst_count", o_count, 0);
        chk("mid_rst_empty", o_empty, 1);
        chk("mid_rst_ready", o_wr_ready, 0);
        model_reset();
        i_wr_valid = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        step(1, 32'h99, 0);
        step(0, '0, 1);
        step(0, '0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute time bound in case the run stalls
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
